alu_seq: RTL and testbench

Parametrised, registered ALU for the datapath. It keeps the existing 4-bit opcode map and adds logical shift-right and iterative multiply/divide. Results and a full flag set are registered, and a start/busy/done handshake is provided. It sits between the register file (x from Rs, bus from Rd) and the writeback mux. The controller issues one operation at a time and writes back on `done`.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_muldiv_iter.sv | 79 +++++++
 rtl/alu_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_seq.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode map and controller state encodings for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_CLR = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_DEC = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [3:0] OP_DIV = 4'd11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the datapath controller and the sequential ALU.
interface alu_seq_if #(parameter int WIDTH = 8);

  logic             start;
  logic [3:0]       alus;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] bus;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_hi;
  logic             zout;
  logic             cout;
  logic             nout;
  logic             vout;
  logic             dz;
  logic             busy;
  logic             done;

  modport master (
    output start, alus, x, bus,
    input  dout, dout_hi, zout, cout, nout, vout, dz, busy, done
  );

  modport slave (
    input  start, alus, x, bus,
    output dout, dout_hi, zout, cout, nout, vout, dz, busy, done
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// hi/lo present the post-iteration values so the caller can register them on the final edge.
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             div_sel,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt_reg;
  logic             run_reg;
  logic             div_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;

  // Multiply: hi accumulates the multiplicand, lo shifts the multiplier out and the product in.
  // Divide: hi holds the partial remainder, lo shifts the dividend out and the quotient in.
  assign mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, a_reg} : '0);
  assign div_shift = {hi_reg, lo_reg[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, a_reg};
  assign div_diff  = div_shift - {1'b0, a_reg};

  always_comb begin
    hi_next = '0;
    lo_next = '0;
    if (div_reg) begin
      hi_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], div_ge};
    end else begin
      hi_next = mul_sum[WIDTH:1];
      lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
    end
  end

  assign done = run_reg && (cnt_reg == CW'(WIDTH - 1));
  assign lo   = lo_next;
  assign hi   = hi_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      run_reg <= 1'b0;
      div_reg <= 1'b0;
      a_reg   <= '0;
      hi_reg  <= '0;
      lo_reg  <= '0;
    end else if (start) begin
      cnt_reg <= '0;
      run_reg <= 1'b1;
      div_reg <= div_sel;
      a_reg   <= div_sel ? y : x;
      lo_reg  <= div_sel ? x : y;
      hi_reg  <= '0;
    end else if (run_reg) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      cnt_reg <= cnt_reg + 1'b1;
      if (done) run_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ops and flags, plus a controller that sequences
// the iterative multiply/divide engine behind a start/busy/done handshake.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave alu
);

  localparam int M = WIDTH - 1;

  state_t           state_reg;
  logic [WIDTH-1:0] dout_reg;
  logic [WIDTH-1:0] hi_reg;
  logic             z_reg, c_reg, n_reg, v_reg, dz_reg, busy_reg, done_reg;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [WIDTH:0]   add_ext, inc_ext, sub_ext, dec_ext;

  logic             is_mul, is_div, div_zero, md_start, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign add_ext = {1'b0, alu.x} + {1'b0, alu.bus};
  assign inc_ext = {1'b0, alu.bus} + {{WIDTH{1'b0}}, 1'b1};
  assign sub_ext = {1'b0, alu.x} - {1'b0, alu.bus};
  assign dec_ext = {1'b0, alu.bus} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (alu.alus)
      OP_ADD: begin
        {res_c, res} = add_ext;
        res_v = (alu.x[M] == alu.bus[M]) && (res[M] != alu.x[M]);
      end
      OP_INC: begin
        {res_c, res} = inc_ext;
        res_v = res[M] & ~alu.bus[M];
      end
      OP_SUB: begin
        {res_c, res} = sub_ext;
        res_v = (alu.x[M] != alu.bus[M]) && (res[M] != alu.x[M]);
      end
      OP_DEC: begin
        {res_c, res} = dec_ext;
        res_v = alu.bus[M] & ~res[M];
      end
      OP_AND: res = alu.x & alu.bus;
      OP_OR:  res = alu.x | alu.bus;
      OP_NOT: res = ~alu.bus;
      OP_SHL: begin
        res   = {alu.bus[M-1:0], 1'b0};
        res_c = alu.bus[M];
      end
      OP_SHR: begin
        res   = {1'b0, alu.bus[M:1]};
        res_c = alu.bus[0];
      end
      default: res = '0;
    endcase
  end

  assign is_mul   = (alu.alus == OP_MUL);
  assign is_div   = (alu.alus == OP_DIV);
  assign div_zero = (alu.bus == '0);
  assign md_start = (state_reg == S_IDLE) && alu.start && (is_mul || (is_div && !div_zero));

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start),
    .div_sel (is_div),
    .x       (alu.x),
    .y       (alu.bus),
    .done    (md_done),
    .lo      (md_lo),
    .hi      (md_hi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      dout_reg  <= '0;
      hi_reg    <= '0;
      z_reg     <= 1'b0;
      c_reg     <= 1'b0;
      n_reg     <= 1'b0;
      v_reg     <= 1'b0;
      dz_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (alu.start) begin
            dz_reg <= 1'b0;
            if (is_mul) begin
              state_reg <= S_MUL;
              busy_reg  <= 1'b1;
            end else if (is_div && !div_zero) begin
              state_reg <= S_DIV;
              busy_reg  <= 1'b1;
            end else if (is_div) begin
              // Divide by zero completes at once: saturated quotient, dividend as remainder.
              dout_reg <= '1;
              hi_reg   <= alu.x;
              z_reg    <= 1'b0;
              c_reg    <= 1'b0;
              n_reg    <= 1'b1;
              v_reg    <= 1'b0;
              dz_reg   <= 1'b1;
              done_reg <= 1'b1;
            end else begin
              dout_reg <= res;
              hi_reg   <= '0;
              z_reg    <= (res == '0);
              c_reg    <= res_c;
              n_reg    <= res[M];
              v_reg    <= res_v;
              done_reg <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (md_done) begin
            dout_reg  <= md_lo;
            hi_reg    <= md_hi;
            z_reg     <= ({md_hi, md_lo} == '0);
            c_reg     <= (md_hi != '0);
            n_reg     <= md_lo[M];
            v_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        S_DIV: begin
          if (md_done) begin
            dout_reg  <= md_lo;
            hi_reg    <= md_hi;
            z_reg     <= (md_lo == '0);
            c_reg     <= 1'b0;
            n_reg     <= md_lo[M];
            v_reg     <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign alu.dout    = dout_reg;
  assign alu.dout_hi = hi_reg;
  assign alu.zout    = z_reg;
  assign alu.cout    = c_reg;
  assign alu.nout    = n_reg;
  assign alu.vout    = v_reg;
  assign alu.dz      = dz_reg;
  assign alu.busy    = busy_reg;
  assign alu.done    = done_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; expected values are hand-computed constants.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  alu_seq_if #(.WIDTH(8)) bif ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .alu (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bif.start = 1'b1;
    bif.alus  = op;
    bif.x     = a;
    bif.bus   = b;
    step();
    bif.start = 1'b0;
  endtask

  // Flags packed as {zout, cout, nout, vout, dz}.
  task automatic chk_res(input string tag, input logic [7:0] ed, input logic [7:0] eh,
                         input logic [4:0] ef);
    chk({tag, " dout"}, 16'(bif.dout), 16'(ed));
    chk({tag, " dout_hi"}, 16'(bif.dout_hi), 16'(eh));
    chk({tag, " flags"}, 16'({bif.zout, bif.cout, bif.nout, bif.vout, bif.dz}), 16'(ef));
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] ed, input logic [4:0] ef);
    issue(op, a, b);
    chk({tag, " busy/done"}, 16'({bif.busy, bif.done}), 16'b01);
    chk_res(tag, ed, 8'h00, ef);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " data"}, {bif.dout, bif.dout_hi}, 16'h0000);
    chk({tag, " status"}, 16'({bif.zout, bif.cout, bif.nout, bif.vout, bif.dz, bif.busy, bif.done}),
        16'h0000);
  endtask

  initial begin
    bif.start = 1'b0;
    bif.alus  = 4'd0;
    bif.x     = 8'h00;
    bif.bus   = 8'h00;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    single("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 5'b11000);
    step();
    chk("add hold done", 16'({bif.done, bif.dout}), 16'h000);
    single("add_7f_01", OP_ADD, 8'h7F, 8'h01, 8'h80, 5'b00110);
    single("sub_80_01", OP_SUB, 8'h80, 8'h01, 8'h7F, 5'b00010);
    single("sub_01_02", OP_SUB, 8'h01, 8'h02, 8'hFF, 5'b01100);
    single("inc_ff",    OP_INC, 8'h00, 8'hFF, 8'h00, 5'b11000);
    single("dec_00",    OP_DEC, 8'h00, 8'h00, 8'hFF, 5'b01100);
    single("dec_80",    OP_DEC, 8'h00, 8'h80, 8'h7F, 5'b00010);
    single("shl_81",    OP_SHL, 8'h00, 8'h81, 8'h02, 5'b01000);
    single("shr_03",    OP_SHR, 8'h00, 8'h03, 8'h01, 5'b01000);
    single("and",       OP_AND, 8'h0C, 8'h0A, 8'h08, 5'b00000);
    single("or",        OP_OR,  8'h0C, 8'h0A, 8'h0E, 5'b00000);
    single("clr",       OP_CLR, 8'h55, 8'hAA, 8'h00, 5'b10000);
    single("op13",      4'd13,  8'hFF, 8'hFF, 8'h00, 5'b10000);
    single("not_0f",    OP_NOT, 8'h00, 8'h0F, 8'hF0, 5'b00100);

    // Reset mid-stream for two cycles with non-zero outputs present.
    rst = 1'b1;
    step();
    step();
    chk_zero("reset_mid");
    rst = 1'b0;

    // MUL FF*FF with an ignored start issued while busy.
    issue(OP_MUL, 8'hFF, 8'hFF);
    chk("mul busy N", 16'({bif.busy, bif.done}), 16'b10);
    for (int i = 1; i < 8; i++) begin
      if (i == 3) begin
        bif.start = 1'b1;
        bif.alus  = OP_ADD;
        bif.x     = 8'h01;
        bif.bus   = 8'h01;
      end else begin
        bif.start = 1'b0;
        bif.x     = 8'h3C;
        bif.bus   = 8'hC3;
      end
      step();
      chk($sformatf("mul busy N+%0d", i), 16'({bif.busy, bif.done}), 16'b10);
    end
    bif.start = 1'b0;
    step();
    chk("mul done N+8", 16'({bif.busy, bif.done}), 16'b01);
    chk_res("mul_ff_ff", 8'h01, 8'hFE, 5'b01000);
    step();
    chk("mul ignored start", 16'({bif.done, bif.dout}), 16'h001);

    // DIV 100/7 = 14 r 2, latency 8.
    issue(OP_DIV, 8'h64, 8'h07);
    for (int i = 1; i < 8; i++) step();
    chk("div busy N+7", 16'({bif.busy, bif.done}), 16'b10);
    step();
    chk("div done N+8", 16'({bif.busy, bif.done}), 16'b01);
    chk_res("div_64_07", 8'h0E, 8'h02, 5'b00000);

    // Divide by zero completes in one cycle.
    issue(OP_DIV, 8'h64, 8'h00);
    chk("div0 busy/done", 16'({bif.busy, bif.done}), 16'b01);
    chk_res("div_64_00", 8'hFF, 8'h64, 5'b00101);
    single("add_clears_dz", OP_ADD, 8'h01, 8'h01, 8'h02, 5'b00000);

    // Reset asserted so that it lands on iteration 4 of a MUL.
    issue(OP_MUL, 8'h0F, 8'h0F);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    chk_zero("reset_in_mul");
    step();
    rst = 1'b0;
    step();
    step();
    chk("after mul reset", 16'({bif.busy, bif.done}), 16'b00);

    // Back-to-back: ADD requested in the done cycle of a DIV is accepted.
    issue(OP_DIV, 8'hC8, 8'h0A);
    for (int i = 1; i < 8; i++) step();
    step();
    chk("b2b div done", 16'({bif.busy, bif.done}), 16'b01);
    chk_res("div_c8_0a", 8'h14, 8'h00, 5'b00000);
    single("b2b_add", OP_ADD, 8'h05, 8'h03, 8'h08, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
